// File: rtl/systolic_feeder_pkg.sv
// Shared FSM encodings, default array geometry and sizing helpers for the systolic feeder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package systolic_feeder_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } fsm_state_e;

    // Geometry shared with PE_array_dynamic
    localparam int ROW_LEN_DEF = 4;
    localparam int COL_LEN_DEF = 5;
    localparam int K_MAX_DEF   = 4;
    localparam int DW_DEF      = 8;

    // Ceiling log2, never below 1 so that index ports always have at least one bit
    function automatic int clog2(input int v);
        int r;
        r = 1;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/systolic_operand_bank.sv
// 2-D operand register bank: one gated write port, every entry readable combinationally.
// Latency: write lands at the clock edge; reads are asynchronous.
// Backpressure: none; writes addressed outside ROWS x COLS are dropped.
// Ports: clk; wr_en_i/wr_row_i/wr_col_i/wr_data_i write port; mem_o full array view [row][col].
module systolic_operand_bank #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int DW   = 8,
    parameter int RW   = 2,
    parameter int CW   = 2
) (
    input  logic                 clk,
    input  logic                 wr_en_i,
    input  logic [RW-1:0]        wr_row_i,
    input  logic [CW-1:0]        wr_col_i,
    input  logic signed [DW-1:0] wr_data_i,
    output logic signed [DW-1:0] mem_o [ROWS][COLS]
);

    logic signed [DW-1:0] mem_q [ROWS][COLS];

    // Contents are intentionally not reset. Matching against every legal
    // address means out-of-range addresses simply hit nothing.
    always_ff @(posedge clk) begin
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (wr_en_i && wr_row_i == RW'(r) && wr_col_i == CW'(c)) begin
                    mem_q[r][c] <= wr_data_i;
                end
            end
        end
    end

    assign mem_o = mem_q;

endmodule

// File: rtl/systolic_feeder.sv
// Feeds skewed A/B operands into a systolic PE array, waits for it to flush, then pulses done.
// Latency: step 0 on the buses the cycle after start is accepted; done KL+max(R,C)-1+DRAIN_CYC+1 cycles after accept.
// Backpressure: none; start and bank writes are ignored while busy.
// Ports: clk/rst_n; wr_* bank write port; k_len/start run control; busy/done status; a_bus/b_bus skewed lanes.
module systolic_feeder
    import systolic_feeder_pkg::*;
#(
    parameter int ROW_len   = ROW_LEN_DEF,
    parameter int COL_len   = COL_LEN_DEF,
    parameter int K_MAX     = K_MAX_DEF,
    parameter int DW        = DW_DEF,
    parameter int DRAIN_CYC = ROW_len + COL_len
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      wr_en,
    input  logic                                      wr_sel,
    input  logic [clog2(imax(ROW_len, K_MAX))-1:0]    wr_row,
    input  logic [clog2(imax(K_MAX, COL_len))-1:0]    wr_col,
    input  logic signed [DW-1:0]                      wr_data,
    input  logic [clog2(K_MAX+1)-1:0]                 k_len,
    input  logic                                      start,
    output logic                                      busy,
    output logic                                      done,
    output logic [ROW_len*DW-1:0]                     a_bus,
    output logic [COL_len*DW-1:0]                     b_bus
);

    localparam int RW    = clog2(imax(ROW_len, K_MAX));
    localparam int CW    = clog2(imax(K_MAX, COL_len));
    localparam int KW    = clog2(K_MAX + 1);
    localparam int MAXRC = imax(ROW_len, COL_len);
    localparam int SW    = clog2(K_MAX + MAXRC + 1);
    localparam int DRW   = clog2(DRAIN_CYC + 1);

    fsm_state_e           state_q;
    logic                 busy_q, done_q;
    logic [ROW_len*DW-1:0] a_q, a_d;
    logic [COL_len*DW-1:0] b_q, b_d;
    logic [SW-1:0]        step_q;
    logic [DRW-1:0]       drain_q;
    logic [KW-1:0]        kl_q;

    logic                 idle, bank_wr;
    logic [KW-1:0]        kl_clamp, kl_cur;
    logic [SW-1:0]        t_cur;
    int                   t_int, kl_int;

    logic signed [DW-1:0] a_mem [ROW_len][K_MAX];
    logic signed [DW-1:0] b_mem [K_MAX][COL_len];

    always_comb begin
        idle     = (state_q == S_IDLE);
        bank_wr  = wr_en && idle;
        kl_clamp = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
        // In IDLE the lanes are evaluated for step 0 of the run about to start
        kl_cur   = idle ? kl_clamp : kl_q;
        t_cur    = idle ? '0 : step_q;
        t_int    = int'(t_cur);
        kl_int   = int'(kl_cur);
    end

    systolic_operand_bank #(
        .ROWS(ROW_len), .COLS(K_MAX), .DW(DW), .RW(RW), .CW(CW)
    ) u_bank_a (
        .clk       (clk),
        .wr_en_i   (bank_wr && !wr_sel),
        .wr_row_i  (wr_row),
        .wr_col_i  (wr_col),
        .wr_data_i (wr_data),
        .mem_o     (a_mem)
    );

    systolic_operand_bank #(
        .ROWS(K_MAX), .COLS(COL_len), .DW(DW), .RW(RW), .CW(CW)
    ) u_bank_b (
        .clk       (clk),
        .wr_en_i   (bank_wr && wr_sel),
        .wr_row_i  (wr_row),
        .wr_col_i  (wr_col),
        .wr_data_i (wr_data),
        .mem_o     (b_mem)
    );

    // Lane i of A carries A[i][t-i]; a write landing on the same edge as the
    // accepting start is forwarded so the run sees the new value at step 0.
    for (genvar gi = 0; gi < ROW_len; gi++) begin : g_a_lane
        logic signed [DW-1:0] lane;
        always_comb begin
            lane = '0;
            for (int k = 0; k < K_MAX; k++) begin
                if (k == t_int - gi && k < kl_int) begin
                    if (bank_wr && !wr_sel && wr_row == RW'(gi) && wr_col == CW'(k)) begin
                        lane = wr_data;
                    end else begin
                        lane = a_mem[gi][k];
                    end
                end
            end
        end
        assign a_d[(gi+1)*DW-1 -: DW] = lane;
    end

    // Lane j of B carries B[t-j][j]
    for (genvar gj = 0; gj < COL_len; gj++) begin : g_b_lane
        logic signed [DW-1:0] lane;
        always_comb begin
            lane = '0;
            for (int k = 0; k < K_MAX; k++) begin
                if (k == t_int - gj && k < kl_int) begin
                    if (bank_wr && wr_sel && wr_row == RW'(k) && wr_col == CW'(gj)) begin
                        lane = wr_data;
                    end else begin
                        lane = b_mem[k][gj];
                    end
                end
            end
        end
        assign b_d[(gj+1)*DW-1 -: DW] = lane;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            step_q  <= '0;
            drain_q <= '0;
            kl_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        kl_q   <= kl_clamp;
                        busy_q <= 1'b1;
                        step_q <= SW'(1);
                        if (kl_clamp == '0) begin
                            state_q <= S_DONE;
                        end else begin
                            a_q     <= a_d;
                            b_q     <= b_d;
                            state_q <= S_FEED;
                        end
                    end
                end
                S_FEED: begin
                    // step_q is the step about to be loaded; reaching T_FEED means feeding is over
                    if (int'(step_q) == int'(kl_q) + MAXRC - 1) begin
                        a_q     <= '0;
                        b_q     <= '0;
                        drain_q <= '0;
                        state_q <= S_DRAIN;
                    end else begin
                        a_q    <= a_d;
                        b_q    <= b_d;
                        step_q <= step_q + SW'(1);
                    end
                end
                S_DRAIN: begin
                    if (drain_q == DRW'(DRAIN_CYC - 1)) begin
                        state_q <= S_DONE;
                    end else begin
                        drain_q <= drain_q + DRW'(1);
                    end
                end
                S_DONE: begin
                    // done and the busy drop appear together in the cycle after DONE
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    step_q  <= '0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign a_bus = a_q;
    assign b_bus = b_q;

endmodule

// File: tb/tb_systolic_feeder.sv
module tb_systolic_feeder;

    localparam int R  = 4;
    localparam int C  = 5;
    localparam int KM = 4;
    localparam int NCAP = 48;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        wr_en = 1'b0;
    logic        wr_sel = 1'b0;
    logic [1:0]  wr_row = '0;
    logic [2:0]  wr_col = '0;
    logic [7:0]  wr_data = '0;
    logic [2:0]  k_len = '0;
    logic        start = 1'b0;
    logic        busy, done;
    logic [31:0] a_bus;
    logic [39:0] b_bus;

    systolic_feeder dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
        .k_len(k_len), .start(start), .busy(busy), .done(done),
        .a_bus(a_bus), .b_bus(b_bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference bank contents
    int am [R][KM];
    int bm [KM][C];

    // Captured run: index n is the cycle after edge E0+n
    int          cap_a [NCAP][R];
    int          cap_b [NCAP][C];
    logic [31:0] cap_araw [NCAP];
    logic [39:0] cap_braw [NCAP];
    int done_idx, busy_err, done_after;

    function automatic int clampk(input int kl);
        return (kl > KM) ? KM : kl;
    endfunction

    function automatic int exp_latency(input int kl);
        int k;
        k = clampk(kl);
        return (k == 0) ? 1 : (k + 5 - 1) + (R + C) + 1;
    endfunction

    function automatic int exp_a(input int i, input int t, input int klc);
        int k;
        k = t - i;
        return (k >= 0 && k < klc) ? am[i][k] : 0;
    endfunction

    function automatic int exp_b(input int j, input int t, input int klc);
        int k;
        k = t - j;
        return (k >= 0 && k < klc) ? bm[k][j] : 0;
    endfunction

    function automatic int stream_diffs(input int klc, input int last);
        int n;
        n = 0;
        for (int t = 0; t <= last && t < NCAP; t++) begin
            for (int i = 0; i < R; i++) if (cap_a[t][i] != exp_a(i, t, klc)) n++;
            for (int j = 0; j < C; j++) if (cap_b[t][j] != exp_b(j, t, klc)) n++;
        end
        return n;
    endfunction

    function automatic int golden_c(input int i, input int j, input int klc);
        int s;
        s = 0;
        for (int k = 0; k < klc; k++) s += am[i][k] * bm[k][j];
        return s;
    endfunction

    // What the PE array accumulates from the observed bus stream
    function automatic int bus_c(input int i, input int j, input int klc);
        int s;
        s = 0;
        for (int k = 0; k < klc; k++) s += cap_a[k+i][i] * cap_b[k+j][j];
        return s;
    endfunction

    task automatic wr(input bit sel, input int row, input int col, input int data);
        @(negedge clk);
        wr_en = 1'b1; wr_sel = sel; wr_row = 2'(row); wr_col = 3'(col); wr_data = 8'(data);
        @(negedge clk);
        wr_en = 1'b0;
        if (!sel && row < R && col < KM) am[row][col] = data;
        if (sel && row < KM && col < C) bm[row][col] = data;
    endtask

    task automatic load_pattern();
        for (int i = 0; i < R; i++) for (int k = 0; k < KM; k++) wr(1'b0, i, k, i*KM + k + 1);
        for (int k = 0; k < KM; k++) for (int j = 0; j < C; j++) wr(1'b1, k, j, k*C + j + 1);
    endtask

    task automatic load_random();
        for (int i = 0; i < R; i++) for (int k = 0; k < KM; k++) wr(1'b0, i, k, int'($urandom_range(0, 255)) - 128);
        for (int k = 0; k < KM; k++) for (int j = 0; j < C; j++) wr(1'b1, k, j, int'($urandom_range(0, 255)) - 128);
    endtask

    task automatic capture(input int kl_in, input bit disturb, input bit wr_start, input int ws_data);
        @(negedge clk);
        start = 1'b1;
        k_len = 3'(kl_in);
        if (wr_start) begin
            wr_en = 1'b1; wr_sel = 1'b0; wr_row = '0; wr_col = '0; wr_data = 8'(ws_data);
            am[0][0] = ws_data;
        end
        @(negedge clk);
        wr_en = 1'b0;
        if (!disturb) start = 1'b0;
        done_idx = -1; busy_err = 0; done_after = 0;
        for (int c = 0; c < NCAP; c++) begin
            if (done_idx >= 0) begin
                if (done) done_after++;
                break;
            end
            cap_araw[c] = a_bus;
            cap_braw[c] = b_bus;
            for (int i = 0; i < R; i++) cap_a[c][i] = int'($signed(a_bus[i*8 +: 8]));
            for (int j = 0; j < C; j++) cap_b[c][j] = int'($signed(b_bus[j*8 +: 8]));
            if (done) begin
                done_idx = c;
                if (busy) busy_err++;
            end else if (!busy) begin
                busy_err++;
            end
            if (disturb) begin
                if (c < 10) begin
                    wr_en = 1'b1; wr_sel = 1'($urandom); wr_row = 2'($urandom);
                    wr_col = 3'($urandom); wr_data = 8'($urandom);
                end else begin
                    wr_en = 1'b0; start = 1'b0;
                end
            end
            @(negedge clk);
        end
        wr_en = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || a_bus !== '0 || b_bus !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b a=%h b=%h, required all 0", busy, done, a_bus, b_bus);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_directed();
        int d;
        load_pattern();
        // Out-of-range writes must be dropped
        wr(1'b0, 0, 4, 99); wr(1'b0, 3, 7, 99); wr(1'b1, 0, 5, 99); wr(1'b1, 3, 7, 99);
        capture(4, 1'b0, 1'b0, 0);
        checks++;
        if (done_idx != 18) begin errors++; $display("FAIL directed_latency: done at %0d, required 18", done_idx); end
        checks++;
        if (cap_araw[0] !== 32'h00000001 || cap_braw[0] !== 40'h0000000001) begin
            errors++; $display("FAIL directed_step0: a=%h b=%h, required 00000001 0000000001", cap_araw[0], cap_braw[0]);
        end
        checks++;
        if (cap_a[1][0] != 2 || cap_a[1][1] != 5 || cap_b[1][0] != 6 || cap_b[1][1] != 2) begin
            errors++; $display("FAIL directed_step1: a=%h b=%h, required a=(2,5,0,0) b=(6,2,0,0,0)", cap_araw[1], cap_braw[1]);
        end
        checks++;
        if (cap_araw[7] !== 32'h0 || cap_b[7][4] != 20) begin
            errors++; $display("FAIL directed_step7: a=%h b_lane4=%0d, required 0 and 20", cap_araw[7], cap_b[7][4]);
        end
        d = stream_diffs(4, done_idx);
        checks++;
        if (d != 0) begin errors++; $display("FAIL directed_stream: %0d lane mismatches, required 0", d); end
        checks++;
        if (bus_c(0, 0, 4) != 110 || bus_c(3, 4, 4) != 750) begin
            errors++; $display("FAIL directed_c_corner: c00=%0d c34=%0d, required 110 750", bus_c(0, 0, 4), bus_c(3, 4, 4));
        end
        d = 0;
        for (int i = 0; i < R; i++) for (int j = 0; j < C; j++) if (bus_c(i, j, 4) != golden_c(i, j, 4)) d++;
        checks++;
        if (d != 0) begin errors++; $display("FAIL directed_c_all: %0d products wrong, required 0", d); end
        checks++;
        if (busy_err != 0 || done_after != 0) begin
            errors++; $display("FAIL directed_handshake: busy_err=%0d extra_done=%0d, required 0 0", busy_err, done_after);
        end
    endtask

    task automatic test_negative();
        int d;
        for (int i = 0; i < R; i++) for (int k = 0; k < KM; k++) wr(1'b0, i, k, -128);
        for (int k = 0; k < KM; k++) for (int j = 0; j < C; j++) wr(1'b1, k, j, 1);
        capture(4, 1'b0, 1'b0, 0);
        checks++;
        if (cap_araw[3] !== 32'h80808080) begin
            errors++; $display("FAIL negative_lanes: a=%h at step 3, required 80808080", cap_araw[3]);
        end
        d = 0;
        for (int i = 0; i < R; i++) for (int j = 0; j < C; j++) if (bus_c(i, j, 4) != -512) d++;
        checks++;
        if (d != 0) begin errors++; $display("FAIL negative_c: %0d products not -512, required 0", d); end
        checks++;
        if (done_idx != exp_latency(4)) begin
            errors++; $display("FAIL negative_latency: done at %0d, required %0d", done_idx, exp_latency(4));
        end
    endtask

    task automatic test_k_zero();
        int d;
        load_pattern();
        capture(0, 1'b0, 1'b0, 0);
        checks++;
        if (done_idx != 1) begin errors++; $display("FAIL kzero_latency: done at %0d, required 1", done_idx); end
        d = stream_diffs(0, done_idx);
        checks++;
        if (d != 0 || busy_err != 0) begin
            errors++; $display("FAIL kzero_buses: %0d nonzero lanes busy_err=%0d, required 0 0", d, busy_err);
        end
    endtask

    task automatic test_k_clamp();
        int d;
        capture(7, 1'b0, 1'b0, 0);
        checks++;
        if (done_idx != 18) begin errors++; $display("FAIL kclamp_latency: done at %0d, required 18", done_idx); end
        d = stream_diffs(4, done_idx);
        checks++;
        if (d != 0) begin errors++; $display("FAIL kclamp_stream: %0d lane mismatches, required 0", d); end
    endtask

    task automatic test_hold_start_and_writes();
        int d, late_busy;
        capture(4, 1'b1, 1'b0, 0);
        checks++;
        if (done_idx != 18 || done_after != 0) begin
            errors++; $display("FAIL hold_latency: done at %0d extra=%0d, required 18 0", done_idx, done_after);
        end
        late_busy = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy || done) late_busy++;
        end
        checks++;
        if (late_busy != 0) begin errors++; $display("FAIL hold_no_rerun: %0d busy cycles, required 0", late_busy); end
        // Bank must be unchanged by the writes issued while busy
        capture(4, 1'b0, 1'b0, 0);
        d = stream_diffs(4, done_idx);
        checks++;
        if (d != 0) begin errors++; $display("FAIL hold_bank_frozen: %0d lane mismatches, required 0", d); end
    endtask

    task automatic test_write_with_start();
        int d;
        capture(4, 1'b0, 1'b1, -77);
        checks++;
        if (cap_a[0][0] != -77) begin
            errors++; $display("FAIL write_start_fwd: lane0 step0=%0d, required -77", cap_a[0][0]);
        end
        d = stream_diffs(4, done_idx);
        checks++;
        if (d != 0) begin errors++; $display("FAIL write_start_stream: %0d lane mismatches, required 0", d); end
    endtask

    task automatic test_mid_reset();
        int d, stray;
        @(negedge clk);
        start = 1'b1; k_len = 3'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (a_bus !== '0 || b_bus !== '0 || busy !== 1'b0) begin
            errors++; $display("FAIL midreset_async: a=%h b=%h busy=%b, required 0", a_bus, b_bus, busy);
        end
        stray = 0;
        repeat (4) begin
            @(negedge clk);
            if (done || busy) stray++;
        end
        rst_n = 1'b1;
        repeat (25) begin
            @(negedge clk);
            if (done || busy) stray++;
        end
        checks++;
        if (stray != 0) begin errors++; $display("FAIL midreset_no_done: %0d active cycles, required 0", stray); end
        capture(4, 1'b0, 1'b0, 0);
        d = stream_diffs(4, done_idx);
        checks++;
        if (d != 0 || done_idx != 18) begin
            errors++; $display("FAIL midreset_rerun: %0d mismatches done at %0d, required 0 and 18", d, done_idx);
        end
    endtask

    task automatic test_random();
        int d, kl, klc;
        for (int it = 0; it < 4; it++) begin
            load_random();
            kl = int'($urandom_range(0, 7));
            klc = clampk(kl);
            capture(kl, 1'b0, 1'b0, 0);
            checks++;
            if (done_idx != exp_latency(kl)) begin
                errors++; $display("FAIL random_latency: k=%0d done at %0d, required %0d", kl, done_idx, exp_latency(kl));
            end
            d = stream_diffs(klc, done_idx);
            for (int i = 0; i < R; i++) for (int j = 0; j < C; j++) if (bus_c(i, j, klc) != golden_c(i, j, klc)) d++;
            checks++;
            if (d != 0) begin errors++; $display("FAIL random_stream: k=%0d %0d mismatches, required 0", kl, d); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_negative();
        test_k_zero();
        load_pattern();
        test_k_clamp();
        test_hold_start_and_writes();
        test_write_with_start();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
